idu_decode: RTL and testbench
=============================

Name: idu_decode

Overview:
- RV64I decode stage; sits between the fetch unit and the EXU operand mux.
- Consumes fetched {instruction, pc} under valid/ready.
- Produces the EXU control and resource fields: ers1, ers2, specinst, imme, pc, plus register indices and ALU op.
- Output is registered, behind a 2-entry skid buffer, so it never creates a combinational ready path back to fetch.

Parameters:
- DATA_WIDTH, 64, datapath width of pc and imme.
- INST_WIDTH, 32, instruction width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all buffered instructions (redirect)
- in_valid_i  in  1  fetch offers an instruction
- in_ready_o  out  1  decode accepts an instruction
- inst_i  in  INST_WIDTH  raw instruction
- pc_i  in  DATA_WIDTH  instruction pc
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  EXU accepts the bundle
- ers1_o  out  1  A operand comes from rs1
- ers2_o  out  1  rs2 is read (B from rs2, or imme for STORE)
- specinst_o  out  3  0 none, 1 JAL, 2 JALR, 3 AUIPC, 4 LUI, 5 STORE
- imme_o  out  DATA_WIDTH  sign-extended immediate
- pc_o  out  DATA_WIDTH  pc of the bundle
- rs1_idx_o, rs2_idx_o, rd_idx_o  out  5 each  register indices
- rd_we_o  out  1  instruction writes rd (forced 0 when rd = x0)
- alu_op_o  out  4  {funct7[5] (R/shift only), funct3}
- is_word_o  out  1  OP-32 / OP-IMM-32
- illegal_o  out  1  unsupported opcode

Behaviour:
- Reset: out_valid_o=0; skid entry empty; in_ready_o=1; every data output 0.
- Handshakes:
  - Transfer in when in_valid_i & in_ready_o.
  - Transfer out when out_valid_o & out_ready_i.
  - Decode-to-output latency is 1 cycle.
- Buffer states: EMPTY, ONE (output register valid), TWO (output register and skid valid).
  - in_ready_o = (state != TWO). It is registered, never a function of out_ready_i.
  - EMPTY + in -> ONE.
  - ONE + in + out -> ONE, output register replaced.
  - ONE + in, no out -> TWO, new bundle goes to skid.
  - ONE + out, no in -> EMPTY.
  - TWO + out -> ONE, skid moves to the output register.
  - Order is always preserved.
- flush_i has priority over all else: next state EMPTY, out_valid_o=0. A same-cycle input is dropped, not accepted. Reset mid-operation behaves the same.
- Decode, per opcode:
  - OP: ers1=1, ers2=1, specinst 0.
  - OP-IMM / LOAD: ers1=1, ers2=0, I-imm.
  - STORE: ers1=1, ers2=1, specinst 5, S-imm, rd_we=0.
  - BRANCH: ers1=1, ers2=1, B-imm, rd_we=0.
  - LUI: ers1=0, specinst 4, U-imm.
  - AUIPC: ers1=0, specinst 3, U-imm.
  - JAL: ers1=0, specinst 1, J-imm.
  - JALR: ers1=1, specinst 2, I-imm.
  - OP-32 / OP-IMM-32: as OP / OP-IMM with is_word=1.
  - Any other opcode (incl. all-zero): illegal_o=1, rd_we=0, ers1=ers2=0, specinst 0. It still flows through the pipe.
- Immediates are sign-extended from bit 31 to DATA_WIDTH. U-imm = {inst[31:12], 12'b0} sign-extended.
- Data outputs are held stable while out_valid_o & !out_ready_i.

Optional Feature:
- IDU_PERF_EN
- Defined: adds output port issued_cnt_o (64), which increments on every output transfer and clears on rst_i (not on flush_i). Also adds stall_cnt_o (64), which increments each cycle out_valid_o & !out_ready_i.
- Undefined: neither port nor counter logic exists.

Test Plan:
- 0x00510093 (addi x1,x2,5), out_ready=1 -> next cycle out_valid=1, rs1_idx=2, rd_idx=1, ers1=1, ers2=0, specinst=0, imme=5, rd_we=1.
- 0x123452B7 (lui x5,0x12345) -> specinst=4, ers1=0, imme=0x0000000012345000. 0xFF9FF0EF (jal x1,-8) at pc 0x80000010 -> specinst=1, imme=0xFFFFFFFFFFFFFFF8, pc_o=0x80000010.
- 0xFE312E23 (sw x3,-4(x2)) -> specinst=5, ers1=1, ers2=1, rs2_idx=3, imme=0xFFFFFFFFFFFFFFFC, rd_we=0.
- out_ready=0 for 3 cycles while fetch offers A, B, C back-to-back -> A and B accepted, in_ready=0 from the cycle after B; outputs hold A. Then out_ready=1 -> A, B, C emerge in order, none lost or duplicated.
- Buffer in TWO, assert flush_i with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle instruction is never emitted. inst 0x00000000 -> illegal_o=1, rd_we=0.

Source files
------------

// File: rtl/idu_decode.sv
// RV64I decode stage: registered decode output behind a 2-entry skid buffer.
// Optional IDU_PERF_EN adds issued/stall performance counters.
module idu_decode #(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  ers1_o,
    output logic                  ers2_o,
    output logic [2:0]            specinst_o,
    output logic [DATA_WIDTH-1:0] imme_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [4:0]            rs1_idx_o,
    output logic [4:0]            rs2_idx_o,
    output logic [4:0]            rd_idx_o,
    output logic                  rd_we_o,
    output logic [3:0]            alu_op_o,
    output logic                  is_word_o,
    output logic                  illegal_o
`ifdef IDU_PERF_EN
    ,
    output logic [63:0]           issued_cnt_o,
    output logic [63:0]           stall_cnt_o
`endif
);

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

    typedef struct packed {
        logic                  ers1;
        logic                  ers2;
        logic [2:0]            specinst;
        logic [DATA_WIDTH-1:0] imme;
        logic [DATA_WIDTH-1:0] pc;
        logic [4:0]            rs1_idx;
        logic [4:0]            rs2_idx;
        logic [4:0]            rd_idx;
        logic                  rd_we;
        logic [3:0]            alu_op;
        logic                  is_word;
        logic                  illegal;
    } bundle_t;

    // state: EMPTY no bundle | ONE output reg valid | TWO output reg + skid valid
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  writes_rd;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic                  do_in, do_out;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    assign imm_i = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){inst_i[31]}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {{(DATA_WIDTH-32){inst_i[31]}}, inst_i[31:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                    inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        writes_rd   = 1'b0;
        dec.pc      = pc_i;
        dec.rs1_idx = inst_i[19:15];
        dec.rs2_idx = inst_i[24:20];
        dec.rd_idx  = inst_i[11:7];
        dec.alu_op  = {1'b0, funct3};
        case (opcode)
            OPC_OP, OPC_OP_32: begin
                dec.ers1      = 1'b1;
                dec.ers2      = 1'b1;
                dec.alu_op[3] = inst_i[30];
                dec.is_word   = (opcode == OPC_OP_32);
                writes_rd     = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                dec.ers1    = 1'b1;
                dec.imme    = imm_i;
                dec.is_word = (opcode == OPC_OP_IMM32);
                writes_rd   = 1'b1;
                // only shifts carry an arithmetic/logical select in funct7[5]
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.alu_op[3] = inst_i[30];
                end
            end
            OPC_LOAD: begin
                dec.ers1  = 1'b1;
                dec.imme  = imm_i;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec.ers1     = 1'b1;
                dec.ers2     = 1'b1;
                dec.specinst = 3'd5;
                dec.imme     = imm_s;
            end
            OPC_BRANCH: begin
                dec.ers1 = 1'b1;
                dec.ers2 = 1'b1;
                dec.imme = imm_b;
            end
            OPC_LUI: begin
                dec.specinst = 3'd4;
                dec.imme     = imm_u;
                writes_rd    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.specinst = 3'd3;
                dec.imme     = imm_u;
                writes_rd    = 1'b1;
            end
            OPC_JAL: begin
                dec.specinst = 3'd1;
                dec.imme     = imm_j;
                writes_rd    = 1'b1;
            end
            OPC_JALR: begin
                dec.ers1     = 1'b1;
                dec.specinst = 3'd2;
                dec.imme     = imm_i;
                writes_rd    = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
                dec.alu_op  = '0;
            end
        endcase
        dec.rd_we = writes_rd && (dec.rd_idx != 5'd0);
    end

    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign do_in       = in_valid_i && in_ready_o;
    assign do_out      = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (do_in) begin
                        out_d   = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (do_in && do_out) begin
                        out_d = dec;
                    end else if (do_in) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end else if (do_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (do_out) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign ers1_o     = out_q.ers1;
    assign ers2_o     = out_q.ers2;
    assign specinst_o = out_q.specinst;
    assign imme_o     = out_q.imme;
    assign pc_o       = out_q.pc;
    assign rs1_idx_o  = out_q.rs1_idx;
    assign rs2_idx_o  = out_q.rs2_idx;
    assign rd_idx_o   = out_q.rd_idx;
    assign rd_we_o    = out_q.rd_we;
    assign alu_op_o   = out_q.alu_op;
    assign is_word_o  = out_q.is_word;
    assign illegal_o  = out_q.illegal;

`ifdef IDU_PERF_EN
    logic [63:0] issued_cnt_q, issued_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;

    // flush does not clear the counters; only reset does
    always_comb begin
        issued_cnt_d = issued_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (do_out) begin
            issued_cnt_d = issued_cnt_q + 64'd1;
        end
        if (out_valid_o && !out_ready_i) begin
            stall_cnt_d = stall_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign issued_cnt_o = issued_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idu_decode.sv
// Scoreboard bench for idu_decode: expected bundles queued on input transfer,
// compared on output transfer; directed skid, flush and reset scenarios.
module tb_idu_decode;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [63:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        ers1_o, ers2_o;
    logic [2:0]  specinst_o;
    logic [63:0] imme_o, pc_o;
    logic [4:0]  rs1_idx_o, rs2_idx_o, rd_idx_o;
    logic        rd_we_o;
    logic [3:0]  alu_op_o;
    logic        is_word_o, illegal_o;
`ifdef IDU_PERF_EN
    logic [63:0] issued_cnt_o, stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    idu_decode #(.DATA_WIDTH(64), .INST_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ers1_o      (ers1_o),
        .ers2_o      (ers2_o),
        .specinst_o  (specinst_o),
        .imme_o      (imme_o),
        .pc_o        (pc_o),
        .rs1_idx_o   (rs1_idx_o),
        .rs2_idx_o   (rs2_idx_o),
        .rd_idx_o    (rd_idx_o),
        .rd_we_o     (rd_we_o),
        .alu_op_o    (alu_op_o),
        .is_word_o   (is_word_o),
        .illegal_o   (illegal_o)
`ifdef IDU_PERF_EN
        ,
        .issued_cnt_o(issued_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        ers1, ers2;
        logic [2:0]  spec;
        logic [63:0] imme;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_we;
        logic [3:0]  alu_op;
        logic        is_word, illegal;
    } exp_t;

    exp_t tbl[12];
    exp_t sb_q[$];
    exp_t drv_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic rnd_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic exp_t mk(input logic [31:0] inst, input logic e1, input logic e2,
                                input logic [2:0] sp, input logic [63:0] imm,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic we, input logic [3:0] op, input logic w,
                                input logic il);
        exp_t e;
        e.inst = inst; e.pc = '0; e.ers1 = e1; e.ers2 = e2; e.spec = sp; e.imme = imm;
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.rd_we = we; e.alu_op = op;
        e.is_word = w; e.illegal = il;
        return e;
    endfunction

    function automatic logic [63:0] ctl_of(input exp_t e);
        return 64'({e.ers1, e.ers2, e.spec, e.rs1, e.rs2, e.rd, e.rd_we,
                    e.alu_op, e.is_word, e.illegal});
    endfunction

    function automatic logic [63:0] ctl_dut();
        return 64'({ers1_o, ers2_o, specinst_o, rs1_idx_o, rs2_idx_o, rd_idx_o, rd_we_o,
                    alu_op_o, is_word_o, illegal_o});
    endfunction

    // Scoreboard: push on accepted input, pop and compare on output transfer.
    always @(negedge clk_i) begin
        exp_t e;
        if (out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ctl", ctl_dut(), ctl_of(e));
                chk("imme", imme_o, e.imme);
                chk("pc", pc_o, e.pc);
            end
        end
        if (flush_i || rst_i) sb_q.delete();
        else if (in_valid_i && in_ready_o) sb_q.push_back(drv_e);
    end

    task automatic send(input exp_t e, input logic [63:0] pc);
        int n = 0;
        e.pc       = pc;
        drv_e      = e;
        inst_i     = e.inst;
        pc_i       = pc;
        in_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(32'h00510093, 1, 0, 0, 64'd5,                  2,  5,  1, 1, 4'd0,  0, 0);
        tbl[1]  = mk(32'h123452B7, 0, 0, 4, 64'h0000_0000_1234_5000, 8,  3,  5, 1, 4'd5,  0, 0);
        tbl[2]  = mk(32'hFF9FF0EF, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 31, 25, 1, 1, 4'd7,  0, 0);
        tbl[3]  = mk(32'hFE312E23, 1, 1, 5, 64'hFFFF_FFFF_FFFF_FFFC, 2,  3, 28, 0, 4'd2,  0, 0);
        tbl[4]  = mk(32'h00000000, 0, 0, 0, 64'd0,                  0,  0,  0, 0, 4'd0,  0, 1);
        tbl[5]  = mk(32'h402081B3, 1, 1, 0, 64'd0,                  1,  2,  3, 1, 4'd8,  0, 0);
        tbl[6]  = mk(32'hFFF0801B, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31,  0, 0, 4'd0,  1, 0);
        tbl[7]  = mk(32'h40335293, 1, 0, 0, 64'h403,                6,  3,  5, 1, 4'd13, 0, 0);
        tbl[8]  = mk(32'h00208863, 1, 1, 0, 64'd16,                 1,  2, 16, 0, 4'd0,  0, 0);
        tbl[9]  = mk(32'h000280E7, 1, 0, 2, 64'd0,                  5,  0,  1, 1, 4'd0,  0, 0);
        tbl[10] = mk(32'hFFFFF397, 0, 0, 3, 64'hFFFF_FFFF_FFFF_F000, 31, 31, 7, 1, 4'd7,  0, 0);
        tbl[11] = mk(32'h00813203, 1, 0, 0, 64'd8,                  2,  8,  4, 1, 4'd3,  0, 0);

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; inst_i = '0; pc_i = '0;
        out_ready_i = 1'b0; rnd_done = 1'b0; drv_e = tbl[0];
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_ctl", ctl_dut(), 64'd0);
        chk("rst_imme", imme_o, 64'd0);
        chk("rst_pc", pc_o, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // streaming decode, every table entry, one cycle latency
        out_ready_i = 1'b1;
        send(tbl[0], 64'h1000);
        chk("latency_valid", 64'(out_valid_o), 64'd1);
        send(tbl[2], 64'h8000_0010);
        for (int i = 1; i < 12; i++) send(tbl[i], 64'h1000 + 64'(4 * i));
        repeat (3) @(posedge clk_i); #1;

        // skid: stall output, offer A,B,C back to back
        out_ready_i = 1'b0;
        send(tbl[0], 64'h2000);
        send(tbl[3], 64'h2004);
        chk("skid_ready_low", 64'(in_ready_o), 64'd0);
        chk("skid_hold_a", pc_o, 64'h2000);
        fork
            send(tbl[5], 64'h2008);
            begin
                repeat (2) begin
                    @(negedge clk_i);
                    chk("skid_hold_a", pc_o, 64'h2000);
                    chk("skid_ready_low", 64'(in_ready_o), 64'd0);
                end
                @(posedge clk_i); #1;
                out_ready_i = 1'b1;
            end
        join
        repeat (3) @(posedge clk_i); #1;

        // flush in ONE with a same-cycle input
        out_ready_i = 1'b0;
        send(tbl[1], 64'h4000);
        drv_e = tbl[7]; inst_i = tbl[7].inst; pc_i = 64'h4004;
        in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush1_valid", 64'(out_valid_o), 64'd0);
        chk("flush1_ready", 64'(in_ready_o), 64'd1);

        // flush in TWO with a same-cycle input
        @(posedge clk_i); #1;
        send(tbl[2], 64'h5000);
        send(tbl[8], 64'h5004);
        drv_e = tbl[9]; inst_i = tbl[9].inst; pc_i = 64'h5008;
        in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush2_valid", 64'(out_valid_o), 64'd0);
        chk("flush2_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk_i); #1;

        // reset mid-operation
        out_ready_i = 1'b0;
        send(tbl[3], 64'h6000);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_valid", 64'(out_valid_o), 64'd0);
        chk("rst_mid_ready", 64'(in_ready_o), 64'd1);
        chk("rst_mid_imme", imme_o, 64'd0);
        @(posedge clk_i); #1;

        // random back-pressure
        fork
            begin
                for (int k = 0; k < 40; k++)
                    send(tbl[$urandom_range(0, 11)], 64'h3000 + 64'(4 * k));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_i); #1;
                    out_ready_i = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready_i = 1'b1;
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk_i);
        @(negedge clk_i);
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        chk("drain_valid", 64'(out_valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
